// File: rtl/ecc_point_check_if.sv
// Request/result bundle for ecc_point_check: operands and start from the
// requester, status and verdict back from the checker.
interface ecc_point_check_if #(
  parameter int LEN = 256
);
  // Handshake: start is a request pulse that is only honoured while busy is
  // low. The operands are captured on the accepting edge and may change
  // afterwards. done pulses for exactly one cycle per accepted request.
  // in_range and on_curve are valid with done and hold until the next
  // accepted start.
  logic           start;
  logic [LEN-1:0] a;
  logic [LEN-1:0] b;
  logic [LEN-1:0] p;
  logic [LEN-1:0] x;
  logic [LEN-1:0] y;
  logic           busy;
  logic           done;
  logic           in_range;
  logic           on_curve;

  modport master (
    output start, a, b, p, x, y,
    input  busy, done, in_range, on_curve
  );

  modport slave (
    input  start, a, b, p, x, y,
    output busy, done, in_range, on_curve
  );
endinterface

// File: rtl/ecc_point_check.sv
// Validates an affine point against y^2 = x^3 + a*x + b mod p using one
// bit-serial modular multiplier. Optional macro: ECC_POINT_CHECK_INFINITY_EN.
module ecc_point_check #(
  parameter int LEN = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  ecc_point_check_if.slave   bus,
  output logic [2:0]         dbg_state
);
  localparam int CW = $clog2(LEN) + 1;
  localparam int W  = LEN + 2;

  typedef enum logic [2:0] {IDLE, RANGE, MUL, ADD, CMP} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [1:0]     op;
  logic [LEN-1:0] ra, rb, rp, rx, ry;
  logic [LEN-1:0] t1, t2, t3, s, acc;
  logic           done_q, in_range_q, on_curve_q;

  logic [LEN-1:0] mcand, mplier, mul_res, add_res;
  logic [CW-1:0]  bit_idx;
  logic           mbit, out_of_range;
  logic [W-1:0]   r0, dbl, sum, add_a, add_b, asum, pw;

  // Multiplier step: r <- 2r mod p, then r <- (r + bit*m) mod p.
  always_comb begin
    mcand   = ry;
    mplier  = rx;
    case (op)
      2'd0:    mcand = rx;
      2'd1:    mcand = t1;
      2'd2:    mcand = ra;
      default: begin
        mcand  = ry;
        mplier = ry;
      end
    endcase
    pw      = {2'b00, rp};
    bit_idx = CW'(LEN - 1) - cnt;
    mbit    = mplier[bit_idx[CW-2:0]];
    r0      = (cnt == '0) ? '0 : {2'b00, acc};
    dbl     = r0 << 1;
    if (dbl >= pw) dbl = dbl - pw;
    sum     = dbl + (mbit ? {2'b00, mcand} : '0);
    if (sum >= pw) sum = sum - pw;
    mul_res = sum[LEN-1:0];

    add_a   = (cnt == '0) ? {2'b00, t1} : {2'b00, s};
    add_b   = (cnt == '0) ? {2'b00, t2} : {2'b00, rb};
    asum    = add_a + add_b;
    if (asum >= pw) asum = asum - pw;
    add_res = asum[LEN-1:0];

    out_of_range = (rx >= rp) || (ry >= rp) || (ra >= rp) || (rb >= rp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= '0;
      ra         <= '0;
      rb         <= '0;
      rp         <= '0;
      rx         <= '0;
      ry         <= '0;
      t1         <= '0;
      t2         <= '0;
      t3         <= '0;
      s          <= '0;
      acc        <= '0;
      done_q     <= 1'b0;
      in_range_q <= 1'b0;
      on_curve_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra         <= bus.a;
            rb         <= bus.b;
            rp         <= bus.p;
            rx         <= bus.x;
            ry         <= bus.y;
            in_range_q <= 1'b0;
            on_curve_q <= 1'b0;
            cnt        <= '0;
            op         <= '0;
            state      <= RANGE;
          end
        end
        RANGE: begin
          if (out_of_range) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
`ifdef ECC_POINT_CHECK_INFINITY_EN
          // (0,0) encodes the point at infinity, which is always valid.
          else if (rx == '0 && ry == '0) begin
            in_range_q <= 1'b1;
            on_curve_q <= 1'b1;
            done_q     <= 1'b1;
            state      <= IDLE;
          end
`endif
          else begin
            in_range_q <= 1'b1;
            cnt        <= '0;
            op         <= '0;
            state      <= MUL;
          end
        end
        MUL: begin
          acc <= mul_res;
          if (cnt == CW'(LEN - 1)) begin
            cnt <= '0;
            op  <= op + 2'd1;
            case (op)
              2'd0, 2'd1: t1 <= mul_res;
              2'd2:       t2 <= mul_res;
              default:    t3 <= mul_res;
            endcase
            if (op == 2'd3) state <= ADD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ADD: begin
          s <= add_res;
          if (cnt == CW'(1)) begin
            cnt   <= '0;
            state <= CMP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CMP: begin
          on_curve_q <= (s == t3);
          done_q     <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.in_range = in_range_q;
  assign bus.on_curve = on_curve_q;
  assign dbg_state    = state;
endmodule
